window_mean_fifo: RTL and testbench

//  Downstream stage of simple_summation. Captures the 32-bit window sum on each

---
 rtl/window_mean_fifo.sv | 123 ++++++++++++
 tb/tb_window_mean_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_mean_fifo.sv
// Captures a window sum on each strobe rising edge, rounds and shifts it to a saturated mean,
// and queues the mean in a small FIFO that drains through a valid/ready port.
module window_mean_fifo #(
  parameter int unsigned SUM_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SUM_WIDTH-1:0]     sum_in,
  input  logic                     sum_strobe,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               overflow_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned EXT_W = SUM_WIDTH + 1;

  localparam logic        [EXT_W-1:0] ROUND   = EXT_W'(1) << (SHIFT - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = $signed(EXT_W'(2 ** (OUT_WIDTH - 1) - 1));
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  logic                     strobe_prev;
  logic                     capture_c;
  logic signed [EXT_W-1:0]  ext_c;
  logic signed [EXT_W-1:0]  q_c;
  logic [OUT_WIDTH-1:0]     sat_c;

  logic                     s1_valid;
  logic [OUT_WIDTH-1:0]     s1_data;

  logic [OUT_WIDTH-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;

  logic                     rd_c;
  logic                     full_c;
  logic                     wr_c;
  logic                     drop_c;
  logic [LVL_W-1:0]         level_nxt_c;
  logic [OUT_WIDTH-1:0]     out_data_nxt_c;

  assign capture_c = sum_strobe & ~strobe_prev;

  // One extra bit of headroom so the rounding add can never wrap before saturation.
  always_comb begin
    ext_c = $signed({sum_in[SUM_WIDTH-1], sum_in} + ROUND);
    q_c   = ext_c >>> SHIFT;
    sat_c = q_c[OUT_WIDTH-1:0];
    if (q_c > SAT_MAX) begin
      sat_c = SAT_MAX[OUT_WIDTH-1:0];
    end else if (q_c < SAT_MIN) begin
      sat_c = SAT_MIN[OUT_WIDTH-1:0];
    end
  end

  // A full FIFO still accepts a write when the head is read on the same edge.
  always_comb begin
    rd_c           = out_valid & out_ready;
    full_c         = (fifo_level == LVL_W'(DEPTH));
    wr_c           = s1_valid & (~full_c | rd_c);
    drop_c         = s1_valid & full_c & ~rd_c;
    level_nxt_c    = fifo_level;
    out_data_nxt_c = out_data;
    case ({wr_c, rd_c})
      2'b10:   level_nxt_c = fifo_level + LVL_W'(1);
      2'b01:   level_nxt_c = fifo_level - LVL_W'(1);
      default: level_nxt_c = fifo_level;
    endcase
    if (level_nxt_c == '0) begin
      out_data_nxt_c = '0;
    end else if ((fifo_level == '0) || (rd_c && (fifo_level == LVL_W'(1)))) begin
      out_data_nxt_c = s1_data;
    end else if (rd_c) begin
      out_data_nxt_c = mem[rd_ptr + PTR_W'(1)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_prev  <= 1'b1;
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      overflow_cnt <= '0;
    end else begin
      strobe_prev <= sum_strobe;
      s1_valid    <= capture_c;
      if (capture_c) begin
        s1_data <= sat_c;
      end
      if (wr_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_level <= level_nxt_c;
      out_valid  <= (level_nxt_c != '0);
      out_data   <= out_data_nxt_c;
      if (drop_c && (overflow_cnt != 8'hFF)) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem[wr_ptr] <= s1_data;
    end
  end

endmodule

// File: tb/tb_window_mean_fifo.sv
// Directed testbench for window_mean_fifo: reset, rounding, saturation, overflow and mid-run reset.
module tb_window_mean_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] sum_in;
  logic        sum_strobe;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic [7:0]  overflow_cnt;

  int checks;
  int failures;

  window_mean_fifo #(
    .SUM_WIDTH(32), .OUT_WIDTH(16), .SHIFT(16), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_strobe(sum_strobe),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; sum_in is scrambled right after the capture edge.
  task automatic send(input logic [31:0] v);
    sum_in     = v;
    sum_strobe = 1'b1;
    tick();
    sum_strobe = 1'b0;
    sum_in     = 32'hDEAD_BEEF;
    tick();
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sum_strobe = 1'b1; sum_in = 32'h0001_8000; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || out_data !== 16'd0 || overflow_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b level=%0d data=%h ovf=%0d required 0/0/0/0",
               out_valid, fifo_level, out_data, overflow_cnt);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL reset_held_strobe: valid=%b level=%0d required 0/0", out_valid, fifo_level);
    end
    sum_strobe = 1'b0;
    tick();
    send(32'h0001_8000);
    checks++;
    if (out_valid !== 1'b1 || fifo_level !== 3'd1 || out_data !== 16'd2) begin
      failures++;
      $display("FAIL reset_recapture: valid=%b level=%0d data=%h required 1/1/0002",
               out_valid, fifo_level, out_data);
    end
    pop();
  endtask

  task automatic test_rounding();
    sum_in = 32'h0001_8000; sum_strobe = 1'b1;
    tick();
    sum_strobe = 1'b0; sum_in = 32'h7FFF_FFFF;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL round_latency: valid=%b at N+1 required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd2) begin
      failures++;
      $display("FAIL round_up: valid=%b data=%h required 1/0002", out_valid, out_data);
    end
    pop();
    send(32'hFFFF_4000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFF) begin
      failures++;
      $display("FAIL round_neg: valid=%b data=%h required 1/ffff", out_valid, out_data);
    end
    pop();
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL round_drain: valid=%b level=%0d required 0/0", out_valid, fifo_level);
    end
  endtask

  task automatic test_saturation();
    send(32'h7FFF_FFFF);
    send(32'h8000_0000);
    checks++;
    if (fifo_level !== 3'd2 || out_data !== 16'h7FFF) begin
      failures++;
      $display("FAIL sat_pos: level=%0d data=%h required 2/7fff", fifo_level, out_data);
    end
    pop();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8000) begin
      failures++;
      $display("FAIL sat_neg: valid=%b data=%h required 1/8000", out_valid, out_data);
    end
    pop();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send(32'(k) << 16);
    checks++;
    if (fifo_level !== 3'd4 || overflow_cnt !== 8'd2) begin
      failures++;
      $display("FAIL ovf_full: level=%0d ovf=%0d required 4/2", fifo_level, overflow_cnt);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(k)) begin
        failures++;
        $display("FAIL ovf_order: valid=%b data=%0d required 1/%0d", out_valid, out_data, k);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL ovf_empty: valid=%b level=%0d required 0/0", out_valid, fifo_level);
    end
  endtask

  task automatic test_held_and_simul();
    sum_in = 32'd3 << 16; sum_strobe = 1'b1;
    repeat (10) tick();
    sum_strobe = 1'b0;
    repeat (2) tick();
    checks++;
    if (fifo_level !== 3'd1 || out_data !== 16'd3) begin
      failures++;
      $display("FAIL held_once: level=%0d data=%0d required 1/3", fifo_level, out_data);
    end
    for (int k = 4; k <= 6; k++) send(32'(k) << 16);
    sum_in = 32'd7 << 16; sum_strobe = 1'b1;
    tick();
    sum_strobe = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || overflow_cnt !== 8'd2 || out_data !== 16'd4) begin
      failures++;
      $display("FAIL simul_full: level=%0d ovf=%0d data=%0d required 4/2/4",
               fifo_level, overflow_cnt, out_data);
    end
    for (int k = 4; k <= 7; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(k)) begin
        failures++;
        $display("FAIL simul_order: valid=%b data=%0d required 1/%0d", out_valid, out_data, k);
      end
      pop();
    end
  endtask

  task automatic test_overflow_sat();
    for (int k = 0; k < 262; k++) send(32'h0001_0000);
    checks++;
    if (fifo_level !== 3'd4 || overflow_cnt !== 8'd255) begin
      failures++;
      $display("FAIL ovf_sat: level=%0d ovf=%0d required 4/255", fifo_level, overflow_cnt);
    end
    repeat (4) pop();
  endtask

  task automatic test_midrun_reset();
    for (int k = 10; k <= 12; k++) send(32'(k) << 16);
    sum_in = 32'd13 << 16; sum_strobe = 1'b1;
    tick();
    sum_strobe = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset_now: valid=%b level=%0d ovf=%0d required 0/0/0",
               out_valid, fifo_level, overflow_cnt);
    end
    tick();
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset_flush: valid=%b level=%0d required 0/0", out_valid, fifo_level);
    end
    send(32'd20 << 16);
    checks++;
    if (fifo_level !== 3'd1 || out_data !== 16'd20) begin
      failures++;
      $display("FAIL mid_reset_fresh: level=%0d data=%0d required 1/20", fifo_level, out_data);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sum_in = '0; sum_strobe = 1'b0; out_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_rounding();
    test_saturation();
    test_overflow();
    test_held_and_simul();
    test_overflow_sat();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
